uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver; both blocks run on the 16x oversampled baud clock d_clk.
- Captures each received byte once, on the rising edge of the receiver's level-type data-ready flag, and stores it in a circular FIFO.
- Presents bytes first-word-fall-through to the consumer (command parser / display logic) with a valid/read handshake.
- Reports fill level, full/empty and a sticky overflow flag.

Parameters:
ADDR_WIDTH, 4, FIFO address bits; DEPTH = 2**ADDR_WIDTH entries (default 16)

Ports:
d_clk  input  1  clock, 16x baud tick clock; all state changes on its rising edge
i_reset  input  1  reset, synchronous, active-high
i_8_data  input  8  received byte from the UART receiver
i_data_ready  input  1  receiver flag; level, held high for several d_clk cycles per byte
o_8_data  output  8  byte at FIFO head; valid only while o_valid=1
o_valid  output  1  FIFO non-empty
i_read  input  1  pop request; honoured only when o_valid=1
o_count  output  ADDR_WIDTH+1  number of stored bytes, 0..DEPTH
o_full  output  1  o_count == DEPTH
o_empty  output  1  o_count == 0
o_overflow  output  1  sticky: a byte was dropped because the FIFO was full
i_clear_overflow  input  1  clears o_overflow

Behaviour:
- Reset (i_reset=1 at a d_clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, o_overflow=0.
  - Edge-detect register rdy_q=1, so a data-ready level already high when reset releases is not captured.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored bytes; outputs become o_valid=0, o_empty=1, o_full=0, o_count=0 on the next cycle.
- Edge detect:
  - rdy_q <= i_data_ready every cycle.
  - push = i_data_ready & ~rdy_q.
  - Exactly one push per high period of i_data_ready, regardless of its length.
  - i_8_data is sampled in the push cycle.
- Write: on push with space available (count<DEPTH, or a pop in the same cycle), mem[wr_ptr] <= i_8_data and wr_ptr increments modulo DEPTH (natural ADDR_WIDTH wrap).
- Read:
  - pop = i_read & o_valid.
  - rd_ptr increments modulo DEPTH; i_read while empty is ignored.
  - o_8_data = mem[rd_ptr] combinationally (FWFT); a byte pushed at edge N appears on o_8_data with o_valid=1 after edge N (1-cycle latency).
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - o_full, o_empty and o_valid are derived from count.
- Boundaries:
  - Push when full, no pop: byte dropped, pointers and count unchanged, o_overflow <= 1.
  - Push and pop together when full: both happen, count stays DEPTH, no overflow.
  - Push and i_read together when empty: push happens, pop ignored, count becomes 1.
  - i_clear_overflow and a new overflow in the same cycle: overflow wins, o_overflow stays 1.
  - Pointer wrap DEPTH-1 -> 0 is transparent to data ordering.
- No other state machine; the only state is the pointers, count, rdy_q and overflow.

Test Plan:
1. Reset, then i_data_ready high for 8 cycles with i_8_data=8'hA5 -> exactly one push; one cycle later o_valid=1, o_8_data=A5, o_count=1.
2. Push 16 bytes 00..0F, then pulse i_read 16 times -> output order 00..0F; after the last pop o_empty=1; o_full was 1 after the 16th push.
3. From full, push 8'h55 without reading -> o_overflow=1, o_count=16, head still 00. Then i_clear_overflow -> o_overflow=0. Repeat with clear and overflow in the same cycle -> o_overflow=1.
4. From full, push 8'h77 and i_read in the same cycle -> o_count=16, o_overflow=0, 77 becomes the last entry. Drain to confirm wrap ordering 01..0F,77.
5. i_data_ready already high when i_reset deasserts -> no push, o_count=0 until i_data_ready falls and rises again.
6. 5 bytes stored, i_reset asserted for one cycle -> o_count=0, o_valid=0; i_read afterwards ignored; new byte 8'h3C is read back correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Each rising edge of the receiver's level-type data-ready flag captures one byte
// into a circular FIFO. The consumer sees the head byte first-word-fall-through
// with a valid/read handshake. Fill level, full/empty and a sticky overflow flag
// are also reported.
module uart_rx_fifo #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  d_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_8_data,
  input  logic                  i_data_ready,
  output logic [7:0]            o_8_data,
  output logic                  o_valid,
  input  logic                  i_read,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  input  logic                  i_clear_overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [7:0]            r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rdyQ;
  logic                  r_overflow;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_write;
  logic w_drop;

  // Decode this cycle's push and pop, and check whether a push can actually be stored.
  always_comb begin
    w_push  = i_data_ready & ~r_rdyQ;
    w_pop   = i_read & (r_count != '0);
    w_full  = (r_count == C_FULL);
    w_write = w_push & (~w_full | w_pop);
    w_drop  = w_push & w_full & ~w_pop;
  end

  assign o_8_data   = r_mem[r_rdPtr];
  assign o_valid    = (r_count != '0);
  assign o_empty    = (r_count == '0);
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Storage array: left uninitialised on reset because the pointers alone define validity.
  always_ff @(posedge d_clk) begin
    if (!i_reset && w_write) begin
      r_mem[r_wrPtr] <= i_8_data;
    end
  end

  // Delay the ready flag so that only its rising edge produces a push.
  // Reset loads 1 so that a flag already high when reset releases is not captured.
  always_ff @(posedge d_clk) begin
    if (i_reset) begin
      r_rdyQ <= 1'b1;
    end else begin
      r_rdyQ <= i_data_ready;
    end
  end

  // Advance the pointers and track the fill level. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge d_clk) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag. A byte dropped in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge d_clk) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

endmodule
